// File: rtl/pb_mailbox_fifo.sv
// pb_mailbox_fifo: N_CH byte FIFOs from a producer PicoBlaze to a consumer
// PicoBlaze, with status and sticky-flag ports and a data-ready interrupt.
module pb_mailbox_fifo #(
  parameter int         N_CH        = 4,
  parameter int         DEPTH       = 16,
  parameter logic [7:0] DATA_BASE   = 8'h00,
  parameter logic [7:0] STATUS_ADDR = 8'h10,
  parameter logic [7:0] FLAG_ADDR   = 8'h11
) (
  input  logic            clk,
  input  logic            reset,
  input  logic [7:0]      p_port_id,
  input  logic            p_write_strobe,
  input  logic [7:0]      p_out_port,
  output logic [7:0]      p_in_port,
  input  logic [7:0]      c_port_id,
  input  logic            c_read_strobe,
  input  logic            c_write_strobe,
  input  logic [7:0]      c_out_port,
  output logic [7:0]      c_in_port,
  output logic            c_irq,
  output logic [N_CH-1:0] ch_full,
  output logic [N_CH-1:0] ch_empty
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [7:0]      p_off;
  logic [7:0]      c_off;
  logic            p_map;
  logic            c_map;
  logic [N_CH-1:0] push_req;
  logic [N_CH-1:0] pop_req;
  logic [N_CH-1:0] push_ok;
  logic [N_CH-1:0] pop_ok;
  logic [7:0]      head [N_CH];
  logic [1:0]      flags;
  logic [1:0]      flag_set;
  logic [1:0]      flag_clr;
  logic [7:0]      c_rd;
  logic [7:0]      p_rd;
  logic [7:0]      nz_pad;
  logic [7:0]      full_pad;

  assign p_off = p_port_id - DATA_BASE;
  assign c_off = c_port_id - DATA_BASE;
  assign p_map = p_off < 8'(N_CH);
  assign c_map = c_off < 8'(N_CH);

  for (genvar k = 0; k < N_CH; k++) begin : g_ch
    logic [7:0]    mem [DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic [CW-1:0] cnt;

    assign ch_full[k]  = cnt == CW'(DEPTH);
    assign ch_empty[k] = cnt == '0;
    assign push_req[k] = p_write_strobe && p_map && (p_off == 8'(k));
    assign pop_req[k]  = c_read_strobe && c_map && (c_off == 8'(k));
    assign pop_ok[k]   = pop_req[k] && !ch_empty[k];
    // a same-cycle pop frees the slot a push into a full channel needs
    assign push_ok[k]  = push_req[k] && (!ch_full[k] || pop_ok[k]);
    assign head[k]     = mem[rd_ptr];

    always_ff @(posedge clk) begin
      if (push_ok[k]) mem[wr_ptr] <= p_out_port;
    end

    always_ff @(posedge clk) begin
      if (!reset) begin
        wr_ptr <= '0;
        rd_ptr <= '0;
        cnt    <= '0;
      end else begin
        if (push_ok[k]) wr_ptr <= wr_ptr + AW'(1);
        if (pop_ok[k])  rd_ptr <= rd_ptr + AW'(1);
        cnt <= cnt + CW'(push_ok[k]) - CW'(pop_ok[k]);
      end
    end
  end

  always_comb begin
    nz_pad              = '0;
    full_pad            = '0;
    nz_pad[N_CH-1:0]    = ~ch_empty;
    full_pad[N_CH-1:0]  = ch_full;
    flag_set[1]         = |(pop_req & ch_empty);
    flag_set[0]         = |(push_req & ~push_ok);
    flag_clr            = 2'b00;
    if (c_write_strobe && (c_port_id == FLAG_ADDR))
      flag_clr = c_out_port[1:0];
    c_rd = 8'h00;
    if (c_port_id == STATUS_ADDR) begin
      c_rd = nz_pad;
    end else if (c_port_id == FLAG_ADDR) begin
      c_rd = {6'b0, flags};
    end else if (c_map) begin
      for (int k = 0; k < N_CH; k++)
        if ((c_off == 8'(k)) && !ch_empty[k]) c_rd = head[k];
    end
    p_rd = (p_port_id == STATUS_ADDR) ? full_pad : 8'h00;
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      p_in_port <= 8'h00;
      c_in_port <= 8'h00;
      c_irq     <= 1'b0;
      flags     <= 2'b00;
    end else begin
      p_in_port <= p_rd;
      c_in_port <= c_rd;
      c_irq     <= |(~ch_empty);
      // set wins over a same-cycle clear
      flags     <= (flags & ~flag_clr) | flag_set;
    end
  end

endmodule

// File: tb/tb_pb_mailbox_fifo.sv
// tb_pb_mailbox_fifo: directed and random checks of pb_mailbox_fifo
// against a queue-per-channel reference model.
module tb_pb_mailbox_fifo;
  localparam int         N_CH  = 4;
  localparam int         DEPTH = 16;
  localparam logic [7:0] DB    = 8'h00;
  localparam logic [7:0] ST    = 8'h10;
  localparam logic [7:0] FL    = 8'h11;

  logic            clk = 1'b0;
  logic            reset = 1'b0;
  logic [7:0]      p_port_id = 8'hFF;
  logic            p_write_strobe = 1'b0;
  logic [7:0]      p_out_port = 8'h00;
  logic [7:0]      p_in_port;
  logic [7:0]      c_port_id = 8'hFF;
  logic            c_read_strobe = 1'b0;
  logic            c_write_strobe = 1'b0;
  logic [7:0]      c_out_port = 8'h00;
  logic [7:0]      c_in_port;
  logic            c_irq;
  logic [N_CH-1:0] ch_full;
  logic [N_CH-1:0] ch_empty;

  pb_mailbox_fifo #(
    .N_CH(N_CH), .DEPTH(DEPTH), .DATA_BASE(DB),
    .STATUS_ADDR(ST), .FLAG_ADDR(FL)
  ) dut (
    .clk(clk), .reset(reset),
    .p_port_id(p_port_id), .p_write_strobe(p_write_strobe),
    .p_out_port(p_out_port), .p_in_port(p_in_port),
    .c_port_id(c_port_id), .c_read_strobe(c_read_strobe),
    .c_write_strobe(c_write_strobe), .c_out_port(c_out_port),
    .c_in_port(c_in_port), .c_irq(c_irq),
    .ch_full(ch_full), .ch_empty(ch_empty)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;

  logic [7:0]      q [N_CH][$];
  logic [1:0]      mflags = 2'b00;
  logic [7:0]      exp_c_in;
  logic [7:0]      exp_p_in;
  logic            exp_irq;
  logic [N_CH-1:0] exp_empty;
  logic [N_CH-1:0] exp_full;

  function automatic void model_clear();
    for (int k = 0; k < N_CH; k++) q[k].delete();
    mflags = 2'b00;
  endfunction

  function automatic void model_flags_view();
    for (int k = 0; k < N_CH; k++) begin
      exp_empty[k] = (q[k].size() == 0);
      exp_full[k]  = (q[k].size() == DEPTH);
    end
  endfunction

  // drive one cycle; expectations come from the queues before the edge
  task automatic step(input logic [7:0] pid, input logic pws,
                      input logic [7:0] pd, input logic [7:0] cid,
                      input logic crs, input logic cws,
                      input logic [7:0] cd);
    logic [7:0] poff;
    logic [7:0] coff;
    logic [7:0] nz;
    logic [7:0] fu;
    logic [1:0] set;
    logic [1:0] clr;
    p_port_id = pid; p_write_strobe = pws; p_out_port = pd;
    c_port_id = cid; c_read_strobe = crs;
    c_write_strobe = cws; c_out_port = cd;
    poff = pid - DB;
    coff = cid - DB;
    nz = 8'h00;
    fu = 8'h00;
    for (int k = 0; k < N_CH; k++) begin
      nz[k] = (q[k].size() != 0);
      fu[k] = (q[k].size() == DEPTH);
    end
    exp_irq = |nz;
    exp_c_in = 8'h00;
    if (cid == ST) exp_c_in = nz;
    else if (cid == FL) exp_c_in = {6'b0, mflags};
    else if (coff < N_CH && q[int'(coff)].size() != 0)
      exp_c_in = q[int'(coff)][0];
    exp_p_in = (pid == ST) ? fu : 8'h00;
    set = 2'b00;
    if (crs && coff < N_CH) begin
      if (q[int'(coff)].size() == 0) set[1] = 1'b1;
      else void'(q[int'(coff)].pop_front());
    end
    if (pws && poff < N_CH) begin
      if (q[int'(poff)].size() < DEPTH) q[int'(poff)].push_back(pd);
      else set[0] = 1'b1;
    end
    clr = (cws && cid == FL) ? cd[1:0] : 2'b00;
    mflags = (mflags & ~clr) | set;
    @(posedge clk);
    #1;
    model_flags_view();
  endtask

  task automatic idle();
    step(8'hFF, 1'b0, 8'h00, 8'hFF, 1'b0, 1'b0, 8'h00);
  endtask

  task automatic test_reset();
    reset = 1'b0;
    p_write_strobe = 1'b0; c_read_strobe = 1'b0; c_write_strobe = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    model_clear();
    checks++;
    if (c_in_port !== 8'h00) begin
      failures++; $display("FAIL reset_c_in got=%h exp=00", c_in_port);
    end
    checks++;
    if (p_in_port !== 8'h00) begin
      failures++; $display("FAIL reset_p_in got=%h exp=00", p_in_port);
    end
    checks++;
    if (ch_empty !== 4'hF) begin
      failures++; $display("FAIL reset_empty got=%h exp=F", ch_empty);
    end
    checks++;
    if (ch_full !== 4'h0) begin
      failures++; $display("FAIL reset_full got=%h exp=0", ch_full);
    end
    checks++;
    if (c_irq !== 1'b0) begin
      failures++; $display("FAIL reset_irq got=%b exp=0", c_irq);
    end
    reset = 1'b1;
  endtask

  task automatic test_basic();
    step(DB + 8'd2, 1'b1, 8'hA5, 8'hFF, 1'b0, 1'b0, 8'h00);
    checks++;
    if (ch_empty[2] !== 1'b0) begin
      failures++; $display("FAIL basic_empty2 got=%b exp=0", ch_empty[2]);
    end
    step(DB + 8'd2, 1'b1, 8'h3C, 8'hFF, 1'b0, 1'b0, 8'h00);
    checks++;
    if (c_irq !== 1'b1) begin
      failures++; $display("FAIL basic_irq_set got=%b exp=1", c_irq);
    end
    step(8'hFF, 1'b0, 8'h00, DB + 8'd2, 1'b1, 1'b0, 8'h00);
    checks++;
    if (c_in_port !== 8'hA5) begin
      failures++; $display("FAIL basic_rd0 got=%h exp=A5", c_in_port);
    end
    step(8'hFF, 1'b0, 8'h00, DB + 8'd2, 1'b1, 1'b0, 8'h00);
    checks++;
    if (c_in_port !== 8'h3C) begin
      failures++; $display("FAIL basic_rd1 got=%h exp=3C", c_in_port);
    end
    checks++;
    if (ch_empty[2] !== 1'b1) begin
      failures++; $display("FAIL basic_empty2_after got=%b exp=1", ch_empty[2]);
    end
    idle();
    checks++;
    if (c_irq !== 1'b0) begin
      failures++; $display("FAIL basic_irq_clr got=%b exp=0", c_irq);
    end
  endtask

  task automatic test_overflow();
    for (int i = 0; i <= 16; i++) begin
      step(DB, 1'b1, 8'(i), 8'hFF, 1'b0, 1'b0, 8'h00);
      if (i == 15) begin
        checks++;
        if (ch_full[0] !== 1'b1) begin
          failures++; $display("FAIL ovf_full got=%b exp=1", ch_full[0]);
        end
      end
    end
    step(ST, 1'b0, 8'h00, FL, 1'b0, 1'b0, 8'h00);
    checks++;
    if (c_in_port !== 8'h01) begin
      failures++; $display("FAIL ovf_flag got=%h exp=01", c_in_port);
    end
    checks++;
    if (p_in_port !== 8'h01) begin
      failures++; $display("FAIL ovf_pstatus got=%h exp=01", p_in_port);
    end
    for (int i = 0; i < 16; i++) begin
      step(8'hFF, 1'b0, 8'h00, DB, 1'b1, 1'b0, 8'h00);
      checks++;
      if (c_in_port !== 8'(i)) begin
        failures++;
        $display("FAIL ovf_pop%0d got=%h exp=%h", i, c_in_port, 8'(i));
      end
    end
    step(8'hFF, 1'b0, 8'h00, FL, 1'b0, 1'b1, 8'h03);
  endtask

  task automatic test_underflow();
    step(8'hFF, 1'b0, 8'h00, DB + 8'd1, 1'b1, 1'b0, 8'h00);
    checks++;
    if (c_in_port !== 8'h00) begin
      failures++; $display("FAIL unf_data got=%h exp=00", c_in_port);
    end
    step(8'hFF, 1'b0, 8'h00, FL, 1'b0, 1'b0, 8'h00);
    checks++;
    if (c_in_port !== 8'h02) begin
      failures++; $display("FAIL unf_flag got=%h exp=02", c_in_port);
    end
    step(8'hFF, 1'b0, 8'h00, FL, 1'b0, 1'b1, 8'h02);
    step(8'hFF, 1'b0, 8'h00, FL, 1'b0, 1'b0, 8'h00);
    checks++;
    if (c_in_port !== 8'h00) begin
      failures++; $display("FAIL unf_clear got=%h exp=00", c_in_port);
    end
  endtask

  task automatic test_full_pushpop();
    for (int i = 0; i < DEPTH; i++)
      step(DB + 8'd3, 1'b1, 8'($urandom), 8'hFF, 1'b0, 1'b0, 8'h00);
    step(DB + 8'd3, 1'b1, 8'h77, DB + 8'd3, 1'b1, 1'b0, 8'h00);
    checks++;
    if (c_in_port !== exp_c_in) begin
      failures++; $display("FAIL fpp_head got=%h exp=%h", c_in_port, exp_c_in);
    end
    checks++;
    if (ch_full[3] !== 1'b1) begin
      failures++; $display("FAIL fpp_full got=%b exp=1", ch_full[3]);
    end
    step(8'hFF, 1'b0, 8'h00, FL, 1'b0, 1'b0, 8'h00);
    checks++;
    if (c_in_port !== 8'h00) begin
      failures++; $display("FAIL fpp_noflag got=%h exp=00", c_in_port);
    end
    for (int i = 0; i < DEPTH; i++) begin
      step(8'hFF, 1'b0, 8'h00, DB + 8'd3, 1'b1, 1'b0, 8'h00);
      checks++;
      if (c_in_port !== exp_c_in) begin
        failures++;
        $display("FAIL fpp_pop%0d got=%h exp=%h", i, c_in_port, exp_c_in);
      end
    end
    checks++;
    if (c_in_port !== 8'h77) begin
      failures++; $display("FAIL fpp_last got=%h exp=77", c_in_port);
    end
  endtask

  task automatic test_wrap();
    logic [7:0] d;
    for (int i = 0; i < 40; i++) begin
      d = 8'($urandom);
      step(DB + 8'd1, 1'b1, d, 8'hFF, 1'b0, 1'b0, 8'h00);
      checks++;
      if (ch_empty[1] !== 1'b0) begin
        failures++; $display("FAIL wrap_push%0d empty=%b exp=0", i, ch_empty[1]);
      end
      step(8'hFF, 1'b0, 8'h00, DB + 8'd1, 1'b1, 1'b0, 8'h00);
      checks++;
      if (c_in_port !== d || ch_empty[1] !== 1'b1) begin
        failures++;
        $display("FAIL wrap_pop%0d got=%h exp=%h empty=%b", i, c_in_port, d,
                 ch_empty[1]);
      end
    end
  endtask

  function automatic logic [7:0] rand_id();
    case ($urandom_range(0, 3))
      0, 1:    return 8'($urandom_range(0, 5));
      2:       return ($urandom_range(0, 1) != 0) ? ST : FL;
      default: return 8'($urandom);
    endcase
  endfunction

  task automatic test_random();
    int push_pct;
    for (int i = 0; i < 400; i++) begin
      push_pct = ((i / 100) % 2 == 0) ? 85 : 25;
      step(rand_id(), $urandom_range(0, 99) < push_pct, 8'($urandom),
           rand_id(), $urandom_range(0, 99) < 50,
           $urandom_range(0, 9) == 0, 8'($urandom));
      checks++;
      if (c_in_port !== exp_c_in || p_in_port !== exp_p_in) begin
        failures++;
        $display("FAIL rnd%0d_ports c_in=%h exp=%h p_in=%h exp=%h", i,
                 c_in_port, exp_c_in, p_in_port, exp_p_in);
      end
      checks++;
      if (ch_empty !== exp_empty || ch_full !== exp_full || c_irq !== exp_irq)
      begin
        failures++;
        $display("FAIL rnd%0d_status empty=%h exp=%h full=%h exp=%h irq=%b exp=%b",
                 i, ch_empty, exp_empty, ch_full, exp_full, c_irq, exp_irq);
      end
    end
  endtask

  task automatic test_reset_mid();
    step(DB, 1'b1, 8'h5A, FL, 1'b0, 1'b0, 8'h00);
    step(DB + 8'd1, 1'b1, 8'hC3, FL, 1'b0, 1'b0, 8'h00);
    test_reset();
    idle();
    checks++;
    if (ch_empty !== 4'hF || c_irq !== 1'b0) begin
      failures++;
      $display("FAIL midreset empty=%h exp=F irq=%b exp=0", ch_empty, c_irq);
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_overflow();
    test_underflow();
    test_full_pushpop();
    test_wrap();
    test_random();
    test_reset_mid();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
